// File: rtl/cpu_cycle_sequencer.sv
// Instruction-cycle sequencer for the 2A03 core: cycle counter, RDY stalls,
// reset/NMI/IRQ/BRK sequencing with NMI edge detection and hijack.
module cpu_cycle_sequencer #(
    parameter int CYC_W   = 3,
    parameter int VEC_CYC = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rdy,
    input  logic             instr_done,
    input  logic             is_brk,
    input  logic             nnmi,
    input  logic             nirq,
    input  logic             iflag,
    output logic [CYC_W-1:0] cyc_count,
    output logic             fetch,
    output logic             force_brk,
    output logic [1:0]       vector_sel,
    output logic             suppress_write,
    output logic             nmi_pending,
    output logic             overrun
);

    typedef enum logic [1:0] {
        RST_SEQ,
        INT_SEQ,
        NORMAL
    } seq_t;

    localparam logic [1:0] VEC_NONE = 2'b00;
    localparam logic [1:0] VEC_NMI  = 2'b01;
    localparam logic [1:0] VEC_RST  = 2'b10;
    localparam logic [1:0] VEC_IRQ  = 2'b11;

    localparam logic [CYC_W-1:0] CYC_MAX = '1;
    localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);
    localparam logic [CYC_W-1:0] CYC_VEC = CYC_W'(VEC_CYC);

    seq_t             seq_q, seq_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [1:0]       vec_q, vec_d;
    logic             nmi_pend_q, nmi_pend_d;
    logic             overrun_q, overrun_d;
    logic             nnmi_prev_q, nnmi_prev_d;
    logic             force_brk_q, force_brk_d;
    logic             suppress_q, suppress_d;
    logic             nmi_edge;
    logic             nmi_clr;

    // The boundary decision looks only at the registered pending flag, so an
    // edge arriving in the instr_done cycle waits for the following boundary.
    always_comb begin
        seq_d       = seq_q;
        cyc_d       = cyc_q;
        vec_d       = vec_q;
        overrun_d   = overrun_q;
        nnmi_prev_d = nnmi;
        nmi_edge    = nnmi_prev_q & ~nnmi;
        nmi_clr     = 1'b0;

        if (rdy) begin
            if (instr_done) begin
                cyc_d = '0;
                if (nmi_pend_q) begin
                    seq_d   = INT_SEQ;
                    vec_d   = VEC_NMI;
                    nmi_clr = 1'b1;
                end else if (!nirq && !iflag) begin
                    seq_d = INT_SEQ;
                    vec_d = VEC_IRQ;
                end else begin
                    seq_d = NORMAL;
                    vec_d = VEC_NONE;
                end
            end else begin
                if (cyc_q == CYC_MAX) begin
                    overrun_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + CYC_ONE;
                end
                // An IRQ or BRK that has not yet fetched its vector is taken over by a pending NMI.
                if (seq_q != RST_SEQ && vec_q == VEC_IRQ && cyc_q == CYC_VEC && nmi_pend_q) begin
                    vec_d   = VEC_NMI;
                    nmi_clr = 1'b1;
                end else if (seq_q == NORMAL && cyc_q == CYC_ONE && is_brk) begin
                    vec_d = VEC_IRQ;
                end
            end
        end

        nmi_pend_d  = nmi_edge | (nmi_pend_q & ~nmi_clr);
        force_brk_d = (seq_d != NORMAL);
        suppress_d  = (seq_d == RST_SEQ);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq_q       <= RST_SEQ;
            cyc_q       <= '0;
            vec_q       <= VEC_RST;
            nmi_pend_q  <= 1'b0;
            overrun_q   <= 1'b0;
            nnmi_prev_q <= 1'b1;
            force_brk_q <= 1'b1;
            suppress_q  <= 1'b1;
        end else begin
            seq_q       <= seq_d;
            cyc_q       <= cyc_d;
            vec_q       <= vec_d;
            nmi_pend_q  <= nmi_pend_d;
            overrun_q   <= overrun_d;
            nnmi_prev_q <= nnmi_prev_d;
            force_brk_q <= force_brk_d;
            suppress_q  <= suppress_d;
        end
    end

    assign cyc_count      = cyc_q;
    assign fetch          = (cyc_q == '0);
    assign force_brk      = force_brk_q;
    assign vector_sel     = vec_q;
    assign suppress_write = suppress_q;
    assign nmi_pending    = nmi_pend_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
// Self-checking bench for cpu_cycle_sequencer: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_cpu_cycle_sequencer;

   localparam int CYC_W   = 3;
   localparam int VEC_CYC = 4;
   localparam int CYC_MAX = (1 << CYC_W) - 1;

   logic             clock = 1'b0;
   logic             reset;
   logic             rdy;
   logic             instrDone;
   logic             isBrk;
   logic             nnmi;
   logic             nirq;
   logic             iflag;
   logic [CYC_W-1:0] cycCount;
   logic             fetch;
   logic             forceBrk;
   logic [1:0]       vectorSel;
   logic             suppressWrite;
   logic             nmiPending;
   logic             overrun;

   int checks = 0;
   int errors = 0;
   bit checkEn = 1'b0;

   // Model state: which kind of sequence is running and what has happened in it
   int mMode;      // 0 reset, 1 interrupt, 2 normal
   int mCnt;
   int mVecBase;   // vector chosen at the start of an interrupt sequence
   bit mBrk;
   bit mHij;
   bit mPend;
   bit mOvf;
   bit mPrev;
   bit edgeSeen;
   int target;

   cpu_cycle_sequencer #(.CYC_W(CYC_W), .VEC_CYC(VEC_CYC)) dut (
      .clock(clock),
      .reset(reset),
      .rdy(rdy),
      .instr_done(instrDone),
      .is_brk(isBrk),
      .nnmi(nnmi),
      .nirq(nirq),
      .iflag(iflag),
      .cyc_count(cycCount),
      .fetch(fetch),
      .force_brk(forceBrk),
      .vector_sel(vectorSel),
      .suppress_write(suppressWrite),
      .nmi_pending(nmiPending),
      .overrun(overrun)
   );

   always #5 clock = ~clock;

   // Vector the datapath should see, derived from the sequence kind
   function automatic int modelVec();
      if (mHij) return 1;
      if (mMode == 0) return 2;
      if (mMode == 1) return mVecBase;
      return mBrk ? 3 : 0;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit d, input bit n, input bit q, input bit f);
      rdy       = r;
      instrDone = d;
      nnmi      = n;
      nirq      = q;
      iflag     = f;
      @(posedge clock);
      #2;
   endtask

   // Behavioural reference, advanced once per clock from the same inputs as the DUT
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mMode = 0; mCnt = 0; mVecBase = 2; mBrk = 0; mHij = 0;
         mPend = 0; mOvf = 0; mPrev = 1;
      end else begin
         edgeSeen = mPrev && !nnmi;
         mPrev    = nnmi;
         if (rdy) begin
            if (instrDone) begin
               if (mPend) begin
                  mMode = 1; mVecBase = 1; mPend = 0;
               end else if (!nirq && !iflag) begin
                  mMode = 1; mVecBase = 3;
               end else begin
                  mMode = 2;
               end
               mCnt = 0; mBrk = 0; mHij = 0;
            end else begin
               if (modelVec() == 3 && mCnt == VEC_CYC && mPend) begin
                  mHij = 1; mPend = 0;
               end
               if (mMode == 2 && mCnt == 1 && isBrk) mBrk = 1;
               if (mCnt == CYC_MAX) mOvf = 1;
               else mCnt++;
            end
         end
         if (edgeSeen) mPend = 1;
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clock) begin
      if (checkEn) begin
         checkOutput("cyc", cycCount, mCnt);
         checkOutput("fetch", fetch, (mCnt == 0));
         checkOutput("forceBrk", forceBrk, (mMode != 2));
         checkOutput("vec", vectorSel, modelVec());
         checkOutput("supWr", suppressWrite, (mMode == 0));
         checkOutput("nmiPend", nmiPending, mPend);
         checkOutput("overrun", overrun, mOvf);
      end
   end

   initial begin
      reset = 1'b1; rdy = 1'b1; instrDone = 1'b0; isBrk = 1'b0;
      nnmi = 1'b1; nirq = 1'b1; iflag = 1'b1;
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
      checkEn = 1'b1;

      // Reset sequence ending at cycle 6
      for (int c = 0; c < 7; c++) begin
         checkOutput("rstVec", vectorSel, 2);
         checkOutput("rstSupWr", suppressWrite, 1);
         checkOutput("rstCyc", cycCount, c);
         applyStimulus(1, c == 6, 1, 1, 1);
      end
      checkOutput("postRstFetch", fetch, 1);
      checkOutput("postRstForce", forceBrk, 0);
      checkOutput("postRstSupWr", suppressWrite, 0);
      checkOutput("postRstVec", vectorSel, 0);

      // NMI wins over a simultaneous IRQ, then the IRQ follows
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("nmiLatched", nmiPending, 1);
      applyStimulus(1, 1, 1, 0, 0);
      checkOutput("nmiSeqVec", vectorSel, 1);
      checkOutput("nmiSeqPend", nmiPending, 0);
      checkOutput("nmiSeqForce", forceBrk, 1);
      for (int c = 0; c < 7; c++) applyStimulus(1, c == 6, 1, 0, 0);
      checkOutput("irqSeqVec", vectorSel, 3);

      // NMI hijacks the IRQ sequence at the vector cycle
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("hijPend", nmiPending, 1);
      checkOutput("hijVecBefore", vectorSel, 3);
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("hijCyc4Vec", vectorSel, 3);
      applyStimulus(1, 0, 1, 0, 0);
      checkOutput("hijVecAfter", vectorSel, 1);
      checkOutput("hijPendClr", nmiPending, 0);
      applyStimulus(1, 0, 1, 1, 0);
      applyStimulus(1, 1, 1, 1, 0);
      checkOutput("hijNoNmiSeq", forceBrk, 0);
      checkOutput("hijNoNmiVec", vectorSel, 0);

      // IRQ masked by iflag, then taken once iflag drops
      applyStimulus(1, 0, 1, 0, 1);
      applyStimulus(1, 1, 1, 0, 1);
      checkOutput("irqMasked", forceBrk, 0);
      applyStimulus(1, 0, 1, 0, 0);
      applyStimulus(1, 1, 1, 0, 0);
      checkOutput("irqUnmaskForce", forceBrk, 1);
      checkOutput("irqUnmaskVec", vectorSel, 3);
      for (int c = 0; c < 7; c++) applyStimulus(1, c == 6, 1, 1, 0);

      // Short instructions, then a RDY stall in a 4-cycle instruction
      applyStimulus(1, 0, 1, 1, 1);
      applyStimulus(1, 1, 1, 1, 1);
      applyStimulus(1, 0, 1, 1, 1);
      applyStimulus(1, 1, 1, 1, 1);
      applyStimulus(1, 0, 1, 1, 1);
      applyStimulus(1, 0, 1, 1, 1);
      checkOutput("stallStart", cycCount, 2);
      repeat (3) applyStimulus(0, 1, 1, 1, 1);
      checkOutput("stallHold", cycCount, 2);
      applyStimulus(1, 0, 1, 1, 1);
      checkOutput("stallResume", cycCount, 3);
      applyStimulus(1, 1, 1, 1, 1);
      checkOutput("stallEnd", cycCount, 0);

      // Randomized traffic against the model
      target = 2;
      for (int i = 0; i < 3000; i++) begin
         rdy       = ($urandom_range(7) != 0);
         instrDone = (mCnt >= target);
         if (mCnt == 0) isBrk = ($urandom_range(3) == 0);
         if ($urandom_range(15) == 0) nnmi = ~nnmi;
         if ($urandom_range(19) == 0) nirq = ~nirq;
         if ($urandom_range(9) == 0) iflag = ~iflag;
         @(posedge clock);
         #2;
         if (rdy && instrDone) target = $urandom_range(6, 1);
      end

      // Saturation and sticky overrun, cleared only by reset
      isBrk = 1'b0;
      repeat (10) applyStimulus(1, 0, 1, 1, 1);
      checkOutput("satCyc", cycCount, 7);
      checkOutput("satOverrun", overrun, 1);
      #1 reset = 1'b1;
      #1;
      checkOutput("rstOverrun", overrun, 0);
      checkOutput("rstCycClr", cycCount, 0);
      checkOutput("rstVecAgain", vectorSel, 2);
      @(posedge clock);
      #2 reset = 1'b0;
      applyStimulus(1, 0, 1, 1, 1);
      checkOutput("afterRstCyc", cycCount, 1);

      checkEn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
